// File: rtl/sw_port_conditioner.sv
// Switch-bus conditioner for CPU input port 1: 2-flop sync, whole-bus debounce, new-data flag.
// Optional sticky rising-edge capture is enabled with `define SW_EDGE_CAPTURE_EN.
module sw_port_conditioner #(
   parameter int WIDTH           = 16,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw_raw,
   input  logic             port_read,
   output logic [WIDTH-1:0] port_data,
   output logic             data_new,
   output logic [WIDTH-1:0] edge_flags
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] port_data_q, port_data_d;
   logic             data_new_q, data_new_d;
   logic             accept;

   // A candidate is accepted only once it has held for the full window and differs from the output.
   assign accept = (sync2_q == cand_q) && (cnt_q == CNT_MAX) && (cand_q != port_data_q);

   always_comb begin
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      port_data_d = port_data_q;
      data_new_d  = data_new_q;
      if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         cnt_d  = '0;
      end else if (cnt_q < CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
      if (port_read) begin
         data_new_d = 1'b0;
      end
      if (accept) begin
         port_data_d = cand_q;
         data_new_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         cand_q      <= '0;
         cnt_q       <= '0;
         port_data_q <= '0;
         data_new_q  <= 1'b0;
      end else begin
         sync1_q     <= sw_raw;
         sync2_q     <= sync1_q;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         port_data_q <= port_data_d;
         data_new_q  <= data_new_d;
      end
   end

   assign port_data = port_data_q;
   assign data_new  = data_new_q;

`ifdef SW_EDGE_CAPTURE_EN
   logic [WIDTH-1:0] edge_q, edge_d;

   // A read clears old edges, but edges from a same-cycle accept still land.
   always_comb begin
      edge_d = edge_q;
      if (port_read) begin
         edge_d = '0;
      end
      if (accept) begin
         edge_d = edge_d | (cand_q & ~port_data_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         edge_q <= '0;
      end else begin
         edge_q <= edge_d;
      end
   end

   assign edge_flags = edge_q;
`else
   assign edge_flags = '0;
`endif

endmodule

// File: tb/tb_sw_port_conditioner.sv
// Scoreboard bench for sw_port_conditioner: stimulus queues expected accepts, a monitor checks them.
module tb_sw_port_conditioner;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] sw_raw;
   logic        port_read;
   logic [15:0] port_data;
   logic        data_new;
   logic [15:0] edge_flags;

`ifdef SW_EDGE_CAPTURE_EN
   localparam bit EDGE_ON = 1'b1;
`else
   localparam bit EDGE_ON = 1'b0;
`endif

   typedef struct {
      logic [15:0] data;
      int          cyc;
      logic [15:0] edges;
   } exp_t;

   exp_t        sb_q[$];
   int          cyc = 0;
   int          pass_cnt = 0;
   int          total_cnt = 0;
   bit          mon_en = 1'b0;
   logic [15:0] prev_pd = '0;

   sw_port_conditioner #(.WIDTH(16), .DEBOUNCE_CYCLES(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .sw_raw     (sw_raw),
      .port_read  (port_read),
      .port_data  (port_data),
      .data_new   (data_new),
      .edge_flags (edge_flags)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
         $display("check %-20s cyc=%0d act=%h exp=%h ok", name, cyc, act, exp);
      end else begin
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [15:0] ex(input logic [15:0] v);
      return EDGE_ON ? v : 16'h0000;
   endfunction

   // Change the switches just after a posedge; the next posedge samples them and
   // the accept is visible 6 posedges later.
   task automatic set_sw(input logic [15:0] v, input logic [15:0] edges);
      exp_t e;
      @(negedge clk);
      sw_raw  = v;
      e.data  = v;
      e.cyc   = cyc + 7;
      e.edges = edges;
      sb_q.push_back(e);
   endtask

   task automatic read_pulse();
      @(negedge clk);
      port_read = 1'b1;
      @(negedge clk);
      port_read = 1'b0;
      check("read_clears_new", {31'd0, data_new}, 32'd0);
      check("read_clears_edge", {16'd0, edge_flags}, 32'd0);
   endtask

   // Monitor: every change of port_data must match the oldest queued expectation.
   always @(negedge clk) begin
      if (mon_en && (port_data !== prev_pd)) begin
         if (sb_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_accept cyc=%0d actual=%h required=none", cyc, port_data);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("accept_data", {16'd0, port_data}, {16'd0, e.data});
            check("accept_cycle", cyc, e.cyc);
            check("accept_data_new", {31'd0, data_new}, 32'd1);
            check("accept_edges", {16'd0, edge_flags}, {16'd0, e.edges});
         end
         prev_pd = port_data;
      end
   end

   initial begin
      rst       = 1'b1;
      sw_raw    = 16'hFFFF;
      port_read = 1'b0;

      // Reset held 3 cycles with all switches high.
      repeat (3) begin
         @(negedge clk);
         check("rst_port_data", {16'd0, port_data}, 32'd0);
         check("rst_data_new", {31'd0, data_new}, 32'd0);
         check("rst_edge_flags", {16'd0, edge_flags}, 32'd0);
      end
      sw_raw  = 16'h0000;
      rst     = 1'b0;
      prev_pd = 16'h0000;
      mon_en  = 1'b1;
      repeat (10) @(negedge clk);
      check("idle_data_new", {31'd0, data_new}, 32'd0);

      // Clean change to 00A5, exact latency checked by the monitor.
      set_sw(16'h00A5, ex(16'h00A5));
      repeat (10) @(negedge clk);
      check("t2_drained", sb_q.size(), 32'd0);

      // Plain read clears the flag.
      read_pulse();

      // Bit0 bouncing every 2 cycles for 40 cycles, ending back at 00A5.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         sw_raw = (i % 2 == 0) ? 16'h00A4 : 16'h00A5;
         @(negedge clk);
      end
      repeat (10) @(negedge clk);
      check("bounce_port_data", {16'd0, port_data}, 32'h0000_00A5);
      check("bounce_data_new", {31'd0, data_new}, 32'd0);

      // Read coincident with the accept of 0F00: accept wins.
      set_sw(16'h0F00, ex(16'h0F00));
      repeat (6) @(negedge clk);
      port_read = 1'b1;
      @(negedge clk);
      port_read = 1'b0;
      @(negedge clk);
      check("coinc_data_new", {31'd0, data_new}, 32'd1);
      check("coinc_port_data", {16'd0, port_data}, 32'h0000_0F00);
      read_pulse();

      // One-cycle glitch on a stable 00A5 produces no accept.
      set_sw(16'h00A5, ex(16'h00A5));
      repeat (10) @(negedge clk);
      read_pulse();
      @(negedge clk);
      sw_raw = 16'h00A4;
      @(negedge clk);
      sw_raw = 16'h00A5;
      repeat (12) @(negedge clk);
      check("glitch_data_new", {31'd0, data_new}, 32'd0);
      check("glitch_port_data", {16'd0, port_data}, 32'h0000_00A5);

      // Edge capture: 0001 -> 0003 flags bit1; back to 0001 keeps it; read clears.
      set_sw(16'h0001, ex(16'h0000));
      repeat (10) @(negedge clk);
      set_sw(16'h0003, ex(16'h0002));
      repeat (10) @(negedge clk);
      set_sw(16'h0001, ex(16'h0002));
      repeat (10) @(negedge clk);
      check("edge_sticky", {16'd0, edge_flags}, {16'd0, ex(16'h0002)});
      read_pulse();

      repeat (5) @(negedge clk);
      check("sb_drained", sb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
